// File: rtl/aes_pkg.sv
// aes_pkg: shared types and helpers for the AES round datapath.
// Mode encodings, ShiftRows row offsets and state byte indexing.
package aes_pkg;

  typedef enum logic [1:0] {
    MODE_FWD = 2'b00,
    MODE_INV = 2'b01,
    MODE_BYP = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  // Rijndael shift amount for a row; wide
  // states skip offset 2 on the lower rows.
  function automatic int shift_offset(
    input int nb,
    input int row
  );
    int s;
    s = row;
    if (nb == 8 && row >= 2) s = row + 1;
    return s;
  endfunction

  // Bit position of the lsb of byte k, with
  // byte 0 in the most significant lane.
  function automatic int byte_lsb(
    input int nb,
    input int k
  );
    return 32 * nb - 8 * (k + 1);
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// shift_rows_perm: combinational ShiftRows / InvShiftRows / bypass.
// Ports: mode (2b), din / dout (32*NB-bit column-major state).
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [1:0]       mode,
  input  logic [32*NB-1:0] din,
  output logic [32*NB-1:0] dout
);

  logic [32*NB-1:0] fwd;
  logic [32*NB-1:0] inv;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int S  = shift_offset(NB, r);
      localparam int LO = byte_lsb(NB, 4 * c + r);
      localparam int LF = byte_lsb(NB, 4 * ((c + S) % NB) + r);
      localparam int LI = byte_lsb(NB, 4 * ((c + NB - S) % NB) + r);
      assign fwd[LO +: 8] = din[LF +: 8];
      assign inv[LO +: 8] = din[LI +: 8];
    end
  end

  // Bypass and reserved both pass the state through.
  always_comb begin
    dout = din;
    unique case (1'b1)
      mode == MODE_FWD: dout = fwd;
      mode == MODE_INV: dout = inv;
      default:          dout = din;
    endcase
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: elastic valid/ready ShiftRows pipeline, DEPTH stages.
// Ports: in_* beat (mode/tag/data), out_* beat (tag/data/err), occupancy.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int DEPTH = 1,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_mode,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [32*NB-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TAG_W-1:0]           out_tag,
  output logic [32*NB-1:0]           out_data,
  output logic                       out_err,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int DW = 32 * NB;
  localparam int OW = $clog2(DEPTH + 1);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("shift_rows_pipe: DEPTH must be 1..4");
  end

  logic [DW-1:0]    perm_data;
  logic [DEPTH-1:0] ld;
  logic [DEPTH-1:0] stg_valid;
  logic [DEPTH-1:0] stg_err;
  logic [TAG_W-1:0] stg_tag  [DEPTH];
  logic [DW-1:0]    stg_data [DEPTH];
  logic [OW-1:0]    occ_q;
  logic [OW-1:0]    occ_d;
  logic             in_xfer;
  logic             out_xfer;

  shift_rows_perm #(
    .NB(NB)
  ) u_perm (
    .mode (in_mode),
    .din  (in_data),
    .dout (perm_data)
  );

  // A stage loads if it, or any stage after it,
  // has a hole, or the output drains this cycle.
  always_comb begin : ready_chain
    logic acc;
    acc = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc   = acc | ~stg_valid[i];
      ld[i] = acc;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid;
    logic             up_err;
    logic [TAG_W-1:0] up_tag;
    logic [DW-1:0]    up_data;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [DW-1:0]    data_q, data_d;

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_err   = (in_mode == MODE_RSV);
      assign up_tag   = in_tag;
      assign up_data  = perm_data;
    end else begin : g_body
      assign up_valid = stg_valid[i-1];
      assign up_err   = stg_err[i-1];
      assign up_tag   = stg_tag[i-1];
      assign up_data  = stg_data[i-1];
    end

    // Payload only moves with a real beat so a
    // bubble never disturbs held data.
    always_comb begin
      valid_d = valid_q;
      err_d   = err_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (ld[i]) begin
        valid_d = up_valid;
        if (up_valid) begin
          err_d  = up_err;
          tag_d  = up_tag;
          data_d = up_data;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        tag_q   <= '0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        err_q   <= err_d;
        tag_q   <= tag_d;
        data_q  <= data_d;
      end
    end

    assign stg_valid[i] = valid_q;
    assign stg_err[i]   = err_q;
    assign stg_tag[i]   = tag_q;
    assign stg_data[i]  = data_q;
  end

  assign in_ready  = ld[0];
  assign in_xfer   = in_valid & ld[0];
  assign out_valid = stg_valid[DEPTH-1];
  assign out_err   = stg_err[DEPTH-1];
  assign out_tag   = stg_tag[DEPTH-1];
  assign out_data  = stg_data[DEPTH-1];
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    unique case (1'b1)
      in_xfer && !out_xfer: occ_d = occ_q + OW'(1);
      out_xfer && !in_xfer: occ_d = occ_q - OW'(1);
      default:              occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occupancy = occ_q;

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, pipelined ShiftRows / InvShiftRows permutation unit for Rijndael states of NB columns (NB = 4, 6 or 8; the AES-128 datapath uses NB = 4).
- The operation mode is selectable per beat and travels with the data; a sideband tag also travels with the data.
- Full-throughput valid/ready elastic pipeline with DEPTH register stages.
- Sits between the SubBytes and MixColumns stages of the iterative and unrolled round datapaths.

Parameters:
- NB, 4, number of state columns; legal values 4, 6, 8; any other value is an elaboration error.
- DEPTH, 1, number of register stages; legal range 1..4.
- TAG_W, 4, width of the sideband tag carried alongside each beat.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat this cycle
- in_mode  in  2  00 forward ShiftRows, 01 InvShiftRows, 10 bypass, 11 reserved
- in_tag  in  TAG_W  sideband tag, passed through unchanged
- in_data  in  32*NB  state input
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_tag  out  TAG_W  tag of the output beat
- out_data  out  32*NB  permuted state
- out_err  out  1  output beat was issued with reserved mode 11
- occupancy  out  $clog2(DEPTH+1)  number of valid beats held in the pipeline

Behaviour:
- Byte mapping: column-major; byte k = in_data[32*NB-1-8k -: 8]; row r = k mod 4, column c = k div 4.
- Shift offsets s(r) per row:
  - NB = 4 or 6: 0, 1, 2, 3.
  - NB = 8: 0, 1, 3, 4.
- Forward (00): out(r,c) = in(r, (c+s(r)) mod NB).
- Inverse (01): out(r,c) = in(r, (c-s(r)) mod NB).
- Bypass (10): out = in.
- Reserved (11): data treated as bypass; out_err = 1 on that beat only.
- The permutation is combinational at the input of stage 0; stages 1..DEPTH-1 are pure registers.
- Each stage holds valid, tag, err and data.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stage i loads when it is empty or stage i+1 (or the output, for the last stage) takes its beat in the same cycle; in_ready = stage-0 load condition.
- in_ready depends on out_ready combinationally through the stage chain; no combinational path exists from in_* to out_*.
- Latency: DEPTH cycles from input transfer to out_valid with no backpressure.
- Throughput: 1 beat/cycle sustained while out_ready = 1.
- Backpressure:
  - With out_ready = 0, the pipeline fills. in_ready drops once all DEPTH stages are valid.
  - out_data, out_tag and out_err remain stable while out_valid && !out_ready.
  - No beat is lost or duplicated.
- Full pipeline with simultaneous input and output transfer: both occur; occupancy is unchanged.
- occupancy = count of valid stages, updated each cycle:
  - +1 on input transfer only
  - -1 on output transfer only
  - unchanged on both or neither
- Reset (asynchronous assert, synchronous deassert by the environment):
  - All stage valid bits 0, so out_valid = 0 and occupancy = 0.
  - out_data = 0, out_tag = 0, out_err = 0.
  - in_ready = 1 in the first cycle after reset release.
  - Reset mid-stream discards all in-flight beats.
- in_mode is sampled per beat only at the input transfer; mode changes between beats need no bubble.

Decomposition:
- Shared package aes_pkg:
  - mode encodings (MODE_FWD, MODE_INV, MODE_BYP, MODE_RSV)
  - function shift_offset(nb, row)
  - byte-index helper function
- One sub-module, shift_rows_perm: purely combinational NB/mode permutation, reusable in the unrolled datapath.
- Pipeline stages are generated inside shift_rows_pipe.

Test Plan:
- NB=4, DEPTH=1, forward: in_data d42711aee0bf98f1b8b45de51e415230 -> out_data d4bf5d30e0b452aeb84111f11e2798e5 one cycle later, out_err = 0.
- NB=4, inverse: in_data d4bf5d30e0b452aeb84111f11e2798e5 -> d42711aee0bf98f1b8b45de51e415230; mode 11 with the same input -> data unchanged, out_err = 1.
- NB=8, forward: in_data bytes 00..1f ascending -> first output column 00 05 0e 13; an inverse pass on that result returns 00..1f.
- DEPTH=3, out_ready held 0, 5 beats offered:
  - 3 accepted, then in_ready = 0 and occupancy = 3.
  - Raise out_ready: beats emerge in order with matching tags, 1 per cycle.
- DEPTH=2, random in_valid/out_ready at 50% over 10k beats with random modes: scoreboard matches every beat; data stable during stalls.
- Assert rst_n low while occupancy = 2: out_valid drops immediately (asynchronously); after release occupancy = 0, in_ready = 1, and no stale beat appears.
